// File: rtl/osd_frame_reg_updater.sv
// Avalon-MM write master for the OSD register bank: queues register updates and
// writes each committed batch at the next frame start so the OSD changes atomically.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for a frame start with a non-empty committed batch
// S_FLUSH | writing the committed batch from the FIFO head to the bank
module osd_frame_reg_updater #(
  parameter int ADDR_WIDTH = 3,
  parameter int FIFO_AW    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_data,
  input  logic                  cmd_commit,
  input  logic                  vsync,
  output logic [ADDR_WIDTH-1:0] av_address,
  output logic                  av_write,
  output logic [31:0]           av_writedata,
  input  logic                  av_waitrequest,
  output logic [FIFO_AW:0]      fifo_level,
  output logic                  busy,
  output logic                  done,
  output logic                  late
);

  localparam int                 DEPTH   = 1 << FIFO_AW;
  localparam int                 EW      = ADDR_WIDTH + 32;
  localparam logic [FIFO_AW:0]   DEPTH_C = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   ONE_C   = (FIFO_AW+1)'(1);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t                r_state;
  logic [EW-1:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0]    r_wr_ptr;
  logic [FIFO_AW-1:0]    r_rd_ptr;
  logic [FIFO_AW:0]      r_count;
  logic [FIFO_AW:0]      r_batch_cnt;
  logic                  r_commit_pend;
  logic                  r_vsync_d;
  logic                  r_av_write;
  logic                  r_done;
  logic                  r_late;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_last;
  logic                  w_vs_rise;
  logic [FIFO_AW:0]      w_count_next;
  logic [EW-1:0]         w_head;

  assign cmd_ready = (r_count != DEPTH_C);
  assign w_push    = cmd_valid & cmd_ready;
  assign w_pop     = (r_state == S_FLUSH) & ~av_waitrequest;
  assign w_last    = w_pop & (r_batch_cnt == ONE_C);
  assign w_vs_rise = vsync & ~r_vsync_d;
  assign w_head    = r_mem[r_rd_ptr];

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + ONE_C;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - ONE_C;
    end
  end

  // Storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_addr, cmd_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_batch_cnt   <= '0;
      r_commit_pend <= 1'b0;
      r_vsync_d     <= 1'b0;
      r_av_write    <= 1'b0;
      r_done        <= 1'b0;
      r_late        <= 1'b0;
    end else begin
      r_vsync_d <= vsync;
      r_count   <= w_count_next;
      r_done    <= 1'b0;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (cmd_commit) begin
            r_batch_cnt <= w_count_next;
          end
          if (w_vs_rise && (r_batch_cnt != '0)) begin
            r_state    <= S_FLUSH;
            r_av_write <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (w_vs_rise) begin
            r_late <= 1'b1;
          end
          if (w_last) begin
            // A commit seen during the flush (or on this cycle) re-arms everything still queued.
            r_state       <= S_IDLE;
            r_av_write    <= 1'b0;
            r_done        <= 1'b1;
            r_commit_pend <= 1'b0;
            r_batch_cnt   <= (r_commit_pend || cmd_commit) ? w_count_next : '0;
          end else begin
            if (w_pop) begin
              r_batch_cnt <= r_batch_cnt - ONE_C;
            end
            if (cmd_commit) begin
              r_commit_pend <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_av_write <= 1'b0;
        end
      endcase
    end
  end

  assign av_write     = r_av_write;
  assign av_address   = r_av_write ? w_head[EW-1:32] : '0;
  assign av_writedata = r_av_write ? w_head[31:0]    : '0;
  assign fifo_level   = r_count;
  assign busy         = (r_state == S_FLUSH);
  assign done         = r_done;
  assign late         = r_late;

endmodule

// File: tb/tb_osd_frame_reg_updater.sv
// Bench for osd_frame_reg_updater: directed frame/commit scenarios followed by random
// traffic, all compared every cycle against a queue-based model of the update flow.
module tb_osd_frame_reg_updater;

  localparam int AW    = 3;
  localparam int FAW   = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_data = '0;
  logic          cmd_commit = 1'b0;
  logic          vsync = 1'b0;
  logic [AW-1:0] av_address;
  logic          av_write;
  logic [31:0]   av_writedata;
  logic          av_waitrequest = 1'b0;
  logic [FAW:0]  fifo_level;
  logic          busy;
  logic          done;
  logic          late;

  osd_frame_reg_updater #(.ADDR_WIDTH(AW), .FIFO_AW(FAW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_commit(cmd_commit),
    .vsync(vsync),
    .av_address(av_address), .av_write(av_write), .av_writedata(av_writedata),
    .av_waitrequest(av_waitrequest),
    .fifo_level(fifo_level), .busy(busy), .done(done), .late(late)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } ent_t;

  // Model: pending updates in push order, how many at the head are armed, and the flush flag.
  ent_t q[$];
  int   armed;
  bit   flushing;
  bit   pend;
  bit   vs_prev;
  bit   m_done;
  bit   m_late;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic m_reset();
    q.delete();
    armed    = 0;
    flushing = 0;
    pend     = 0;
    vs_prev  = 0;
    m_done   = 0;
    m_late   = 0;
  endtask

  task automatic m_update();
    bit   push, pop, rise, exiting, start;
    ent_t e;
    if (!rst_n) begin
      m_reset();
      return;
    end
    push    = cmd_valid && (q.size() < DEPTH);
    pop     = flushing && !av_waitrequest;
    rise    = vsync && !vs_prev;
    exiting = 0;
    start   = 0;
    m_done  = 0;
    if (pop) begin
      void'(q.pop_front());
      armed--;
      exiting = (armed == 0);
    end
    if (push) begin
      e.a = cmd_addr;
      e.d = cmd_data;
      q.push_back(e);
    end
    if (flushing) begin
      if (rise) m_late = 1;
      if (exiting) begin
        m_done   = 1;
        flushing = 0;
        armed    = (pend || cmd_commit) ? q.size() : 0;
        pend     = 0;
      end else if (cmd_commit) begin
        pend = 1;
      end
    end else begin
      start = rise && (armed != 0);
      if (cmd_commit) armed = q.size();
      if (start) flushing = 1;
    end
    vs_prev = vsync;
  endtask

  // Compare this cycle's outputs, clock once, advance the model with the applied inputs.
  task automatic step();
    chk("av_write", av_write, flushing);
    chk("av_address", av_address, flushing ? q[0].a : '0);
    chk("av_writedata", av_writedata, flushing ? q[0].d : 32'h0);
    chk("fifo_level", fifo_level, q.size());
    chk("cmd_ready", cmd_ready, q.size() < DEPTH);
    chk("busy", busy, flushing);
    chk("done", done, m_done);
    chk("late", late, m_late);
    @(posedge clk);
    m_update();
    #1;
    cyc++;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [31:0] d, input bit c);
    cmd_valid  = 1'b1;
    cmd_addr   = a;
    cmd_data   = d;
    cmd_commit = c;
    step();
    cmd_valid  = 1'b0;
    cmd_commit = 1'b0;
  endtask

  task automatic commit();
    cmd_commit = 1'b1;
    step();
    cmd_commit = 1'b0;
  endtask

  task automatic frame();
    vsync = 1'b1;
    step();
    step();
    vsync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    int period;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    m_reset();
    #1;
    idle(1);
    rst_n = 1'b1;
    idle(2);

    // Two entries, committed, held until the frame start.
    push(3'd2, 32'h11, 1'b0);
    push(3'd5, 32'h22, 1'b0);
    commit();
    idle(4);
    frame();
    idle(4);

    // Partial commit: only the first three go out; the rest wait for their own commit.
    for (int i = 0; i < 3; i++) push(AW'(i), 32'hA0 + i, i == 2);
    push(3'd6, 32'hB0, 1'b0);
    push(3'd7, 32'hB1, 1'b0);
    frame();
    idle(5);
    frame();
    idle(3);
    commit();
    frame();
    idle(4);

    // Fill to full, attempt a ninth push, then flush with pointer wrap; repeat.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH + 1; i++) push(AW'(i + r), $urandom, 1'b0);
      commit();
      frame();
      idle(10);
    end

    // Waitrequest stalls the first write for three cycles.
    push(3'd1, 32'hC1, 1'b0);
    push(3'd4, 32'hC4, 1'b1);
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    av_waitrequest = 1'b1;
    idle(3);
    av_waitrequest = 1'b0;
    idle(4);

    // Second frame start mid-flush, and a commit of new entries during the flush.
    for (int i = 0; i < DEPTH; i++) push(AW'(7 - i), $urandom, i == DEPTH - 1);
    frame();
    av_waitrequest = 1'b1;
    idle(2);
    av_waitrequest = 1'b0;
    step();
    av_waitrequest = 1'b1;
    frame();
    av_waitrequest = 1'b0;
    push(3'd3, 32'hD3, 1'b0);
    push(3'd0, 32'hD0, 1'b1);
    idle(8);
    frame();
    idle(4);

    // Reset in the middle of a flush drops everything.
    for (int i = 0; i < 5; i++) push(AW'(i), $urandom, i == 4);
    frame();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle(2);
    frame();
    idle(3);

    // Random traffic.
    period = 20;
    for (int t = 0; t < 3000; t++) begin
      if ((t % period) == 0) period = $urandom_range(6, 40);
      cmd_valid      = ($urandom_range(0, 1) == 1);
      cmd_addr       = AW'($urandom);
      cmd_data       = $urandom;
      cmd_commit     = ($urandom_range(0, 9) == 0);
      vsync          = ((t % period) < 3);
      av_waitrequest = ($urandom_range(0, 3) == 0);
      rst_n          = ($urandom_range(0, 399) != 0);
      step();
    end
    cmd_valid = 1'b0;
    cmd_commit = 1'b0;
    vsync = 1'b0;
    av_waitrequest = 1'b0;
    rst_n = 1'b1;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/osd_frame_reg_updater.md
Name: osd_frame_reg_updater

Overview:
- Avalon-MM write master that feeds the OSD register bank (8 x 32-bit, write-only usage, no waitrequest on the bank).
- Software/CPU-side logic queues (address, data) register updates into an internal FIFO and marks batch boundaries with a commit pulse.
- Committed updates are written to the register bank only at the next frame start (vsync rising edge), so OSD parameters change atomically between frames.

Parameters:
- ADDR_WIDTH, 3, register-bank address width; must match the bank.
- FIFO_AW, 3, log2 of FIFO depth (default depth 8 entries).

Ports:
- clk  input  1  single clock.
- rst_n  input  1  synchronous active-low reset.
- cmd_valid  input  1  update entry valid.
- cmd_ready  output  1  FIFO can accept an entry.
- cmd_addr  input  ADDR_WIDTH  target register index.
- cmd_data  input  32  value to write.
- cmd_commit  input  1  one-cycle pulse; arms all entries queued so far, including any accepted this cycle.
- vsync  input  1  frame sync level from the timing generator.
- av_address  output  ADDR_WIDTH  to bank.
- av_write  output  1  to bank.
- av_writedata  output  32  to bank.
- av_waitrequest  input  1  tie to 0 for the OSD bank; honoured anyway.
- fifo_level  output  FIFO_AW+1  current entry count.
- busy  output  1  high while in FLUSH.
- done  output  1  one-cycle pulse after a batch completes.
- late  output  1  sticky flag: a frame start arrived while FLUSH was still active.

Behaviour:
- Reset is synchronous on rst_n=0 and clears all state in the next clk edge:
  - FIFO emptied, batch_cnt=0, commit_pend=0, vsync_d=0, state=IDLE.
  - All outputs 0, except cmd_ready=1.
  - Reset during FLUSH aborts the flush; queued entries are lost.
- FIFO:
  - Register array with rd/wr pointers and a FIFO_AW+1 count.
  - Push on cmd_valid & cmd_ready; cmd_ready = (count != depth). No bypass when full.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo depth.
- batch_cnt (FIFO_AW+1 bits): number of committed entries at the FIFO head.
  - cmd_commit in IDLE: batch_cnt <= count_next (after this cycle's push).
  - cmd_commit in FLUSH: sets commit_pend; on the FLUSH->IDLE cycle, batch_cnt <= count_next and commit_pend <= 0.
  - Commit with an empty FIFO: batch_cnt=0, no effect.
- Frame-start detect: vsync_d <= vsync; vs_rise = vsync & ~vsync_d.
- State machine IDLE / FLUSH:
  - IDLE -> FLUSH when vs_rise & batch_cnt != 0.
  - In FLUSH:
    - av_write=1; av_address/av_writedata = FIFO head (combinational from the array).
    - When ~av_waitrequest, the entry is accepted: pop and decrement batch_cnt.
    - The write carrying batch_cnt==1 that is accepted moves the FSM to IDLE and registers done=1 for exactly the following cycle.
  - vs_rise in FLUSH: ignored for sequencing; sets late=1. late clears only on reset.
  - vs_rise in IDLE with batch_cnt=0: no action.
- Outputs:
  - av_write is registered from state (high from the first cycle in FLUSH).
  - av_address and av_writedata read 0 whenever av_write=0.
  - busy = (state==FLUSH).
- Latency (waitrequest=0, K committed entries, rising edge sampled at cycle N):
  - av_write high for cycles N+1..N+K.
  - done high at N+K+1.
- Ordering: writes occur in push order. Uncommitted entries remain queued and cmd_ready keeps accepting during FLUSH.

Test Plan:
- Reset, then push (2,0x11),(5,0x22), commit, hold vsync=0 -> no av_write. Vsync rises at cycle N -> av_write at N+1 (addr 2, 0x11) and N+2 (addr 5, 0x22); done at N+3; fifo_level 0.
- Push 3 entries, commit, push 2 more, vsync rise -> exactly 3 writes; fifo_level=2. Next vsync rise -> no writes. Commit then vsync rise -> the remaining 2 writes.
- Fill 8 entries -> cmd_ready=0 and a 9th push is not accepted. Commit + vsync -> 8 back-to-back writes with correct wrap order. Refill across the pointer wrap and repeat -> data matches.
- av_waitrequest high for 3 cycles on the first write -> address/data held stable, no pop. Flush completes 3 cycles later; done asserted once.
- Second vsync rise during an 8-write flush with waitrequest stalls -> late=1 and the flush is not restarted. Commit pulsed during FLUSH -> new entries flushed on the following frame.
- rst_n=0 in the middle of a flush -> av_write=0, fifo_level=0, busy=0 after the clock edge; the next vsync rise issues no writes.
